// File: rtl/calc_keypad_controller.sv
// rtl/calc_keypad_controller.sv - cursor-driven keypad front end for a 16-bit calculator ALU
module calc_keypad_controller #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic        mode,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic [2:0]  pos_x,
  output logic [1:0]  pos_y,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic [2:0]  op,
  output logic [15:0] input_screen,
  output logic [1:0]  state,
  output logic        alu_start
);

  typedef enum logic [1:0] {
    S_OP1    = 2'd0,
    S_OP2    = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t      cur;
  logic [15:0] entry;
  logic [2:0]  count;

  // Linear key index: 0..15 digits, 16..20 operators, 21 CE, 22 CLR, 23 EXE.
  logic [4:0]  key_idx;
  logic        digit_legal;
  logic        is_op;
  logic        is_ce;
  logic        is_clr;
  logic        is_exe;
  logic        room;
  logic [2:0]  op_code;
  logic [15:0] shifted;

  assign key_idx     = {3'b000, pos_y} * 5'd6 + {2'b00, pos_x};
  assign digit_legal = (key_idx < 5'd16) && (mode || (key_idx[3:0] < 4'd10));
  assign is_op       = (key_idx >= 5'd16) && (key_idx <= 5'd20);
  assign is_ce       = (key_idx == 5'd21);
  assign is_clr      = (key_idx == 5'd22);
  assign is_exe      = (key_idx == 5'd23);
  assign room        = (count < 3'(MAX_DIGITS));
  assign op_code     = key_idx[2:0];
  assign shifted     = {entry[11:0], key_idx[3:0]};
  assign state       = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x        <= 3'd0;
      pos_y        <= 2'd0;
      op1          <= 16'd0;
      op2          <= 16'd0;
      op           <= 3'd0;
      input_screen <= 16'd0;
      cur          <= S_OP1;
      alu_start    <= 1'b0;
      entry        <= 16'd0;
      count        <= 3'd0;
    end else begin
      alu_start <= 1'b0;

      // Cursor moves in every state; the key decoded below uses the pre-move position.
      if (btn_up)
        pos_y <= pos_y - 2'd1;
      else if (btn_down)
        pos_y <= pos_y + 2'd1;
      else if (btn_left)
        pos_x <= (pos_x == 3'd0) ? 3'd5 : pos_x - 3'd1;
      else if (btn_right)
        pos_x <= (pos_x == 3'd5) ? 3'd0 : pos_x + 3'd1;

      if (btn_center && is_clr) begin
        op1          <= 16'd0;
        op2          <= 16'd0;
        op           <= 3'd0;
        entry        <= 16'd0;
        count        <= 3'd0;
        input_screen <= 16'd0;
        cur          <= S_OP1;
      end else begin
        case (cur)
          S_OP1, S_OP2: begin
            if (btn_center) begin
              if (digit_legal) begin
                if (room) begin
                  entry        <= shifted;
                  count        <= count + 3'd1;
                  input_screen <= shifted;
                end
              end else if (is_op) begin
                op <= op_code;
                if (cur == S_OP1) begin
                  op1          <= entry;
                  entry        <= 16'd0;
                  count        <= 3'd0;
                  input_screen <= 16'd0;
                  cur          <= S_OP2;
                end
              end else if (is_ce) begin
                entry        <= 16'd0;
                count        <= 3'd0;
                input_screen <= 16'd0;
              end else if (is_exe && (cur == S_OP2)) begin
                op2       <= entry;
                alu_start <= 1'b1;
                cur       <= S_WAIT;
              end
            end
          end

          S_WAIT: begin
            if (alu_done) begin
              input_screen <= alu_result;
              op1          <= alu_result;
              entry        <= 16'd0;
              count        <= 3'd0;
              cur          <= S_RESULT;
            end
          end

          S_RESULT: begin
            if (btn_center) begin
              if (digit_legal) begin
                entry        <= {12'd0, key_idx[3:0]};
                count        <= 3'd1;
                input_screen <= {12'd0, key_idx[3:0]};
                cur          <= S_OP1;
              end else if (is_op) begin
                op           <= op_code;
                entry        <= 16'd0;
                count        <= 3'd0;
                input_screen <= 16'd0;
                cur          <= S_OP2;
              end else if (is_ce) begin
                entry        <= 16'd0;
                count        <= 3'd0;
                input_screen <= 16'd0;
                cur          <= S_OP1;
              end
            end
          end

          default: cur <= S_OP1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_keypad_controller.sv
// tb/tb_calc_keypad_controller.sv - directed and randomized checks against a keypad calculator model
module tb_calc_keypad_controller;

  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
  logic        mode = 1'b1;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'd0;
  logic [2:0]  pos_x;
  logic [1:0]  pos_y;
  logic [15:0] op1, op2, input_screen;
  logic [2:0]  op;
  logic [1:0]  state;
  logic        alu_start;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: entry kept as a list of digits, keys as symbolic codes.
  int          m_x, m_y, m_state, m_op;
  logic [15:0] m_op1, m_op2, m_result;
  bit          m_start;
  int          m_q[$];

  calc_keypad_controller #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_center(btn_center),
    .mode(mode), .alu_done(alu_done), .alu_result(alu_result),
    .pos_x(pos_x), .pos_y(pos_y), .op1(op1), .op2(op2), .op(op),
    .input_screen(input_screen), .state(state), .alu_start(alu_start)
  );

  always #5 clk = ~clk;

  // Codes: 0..15 digits, 100..104 ADD SUB MUL AND OR, 200 CE, 201 CLR, 202 EXE.
  function automatic int key_code(int x, int y);
    int idx = y * 6 + x;
    if (idx < 16) return idx;
    if (idx < 21) return 100 + idx - 16;
    return 200 + idx - 21;
  endfunction

  function automatic logic [15:0] entry_value();
    logic [15:0] v = 16'd0;
    for (int i = 0; i < m_q.size(); i++) v = (v << 4) | 16'(m_q[i]);
    return v;
  endfunction

  function automatic logic [15:0] m_screen();
    return (m_state == 3) ? m_result : entry_value();
  endfunction

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_state = 0; m_op = 0;
    m_op1 = 0; m_op2 = 0; m_result = 0; m_start = 0;
    m_q.delete();
  endfunction

  function automatic void model_step(bit u, bit d, bit l, bit r, bit c, bit dn, logic [15:0] res);
    int  k      = key_code(m_x, m_y);
    bit  dig    = c && (k < 16) && (mode || k < 10);
    bit  is_op  = c && (k >= 100) && (k <= 104);
    m_start = 0;
    if (u) m_y = (m_y + 3) % 4;
    else if (d) m_y = (m_y + 1) % 4;
    else if (l) m_x = (m_x + 5) % 6;
    else if (r) m_x = (m_x + 1) % 6;
    if (c && k == 201) begin
      m_op1 = 0; m_op2 = 0; m_op = 0; m_result = 0; m_q.delete(); m_state = 0;
    end else if (m_state == 0 || m_state == 1) begin
      if (dig) begin
        if (m_q.size() < MAXD) m_q.push_back(k);
      end else if (is_op) begin
        m_op = k - 100;
        if (m_state == 0) begin m_op1 = entry_value(); m_q.delete(); m_state = 1; end
      end else if (c && k == 200) begin
        m_q.delete();
      end else if (c && k == 202 && m_state == 1) begin
        m_op2 = entry_value(); m_start = 1; m_state = 2;
      end
    end else if (m_state == 2) begin
      if (dn) begin m_result = res; m_op1 = res; m_q.delete(); m_state = 3; end
    end else begin
      if (dig) begin
        m_q.delete(); m_q.push_back(k); m_state = 0;
      end else if (is_op) begin
        m_op = k - 100; m_q.delete(); m_state = 1;
      end else if (c && k == 200) begin
        m_q.delete(); m_state = 0;
      end
    end
  endfunction

  task automatic step(input bit u, input bit d, input bit l, input bit r, input bit c, input bit dn, input logic [15:0] res);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_center = c;
    alu_done = dn; alu_result = res;
    model_step(u, d, l, r, c, dn, res);
    @(posedge clk);
    #1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_center = 0; alu_done = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 16'd0);
  endtask

  task automatic finish_alu(input logic [15:0] res);
    step(0, 0, 0, 0, 0, 1, res);
  endtask

  task automatic press_key(input int kx, input int ky);
    while (m_x != kx) step(0, 0, 0, 1, 0, 0, 16'd0);
    while (m_y != ky) step(0, 1, 0, 0, 0, 0, 16'd0);
    step(0, 0, 0, 0, 1, 0, 16'd0);
  endtask

  task automatic press_digit(input int dgt);
    press_key(dgt % 6, dgt / 6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; btn_up = 1; btn_right = 1; btn_center = 1; alu_done = 1; alu_result = 16'hffff;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rst = 0; btn_up = 0; btn_right = 0; btn_center = 0; alu_done = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if ({pos_x, pos_y} !== 5'd0) $display("FAIL reset_pos got x=%0d y=%0d want 0 0", pos_x, pos_y); else n_pass++;
    n_total++; if ({op1, op2} !== 32'd0) $display("FAIL reset_ops got op1=%h op2=%h want 0 0", op1, op2); else n_pass++;
    n_total++; if (op !== 3'd0) $display("FAIL reset_op got %0d want 0", op); else n_pass++;
    n_total++; if (input_screen !== 16'd0) $display("FAIL reset_screen got %h want 0000", input_screen); else n_pass++;
    n_total++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
    n_total++; if (alu_start !== 1'b0) $display("FAIL reset_start got %b want 0", alu_start); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    step(0, 0, 1, 0, 0, 0, 16'd0);
    step(1, 0, 0, 0, 0, 0, 16'd0);
    n_total++; if (pos_x !== 3'd5) $display("FAIL wrap_left got x=%0d want 5", pos_x); else n_pass++;
    n_total++; if (pos_y !== 2'd3) $display("FAIL wrap_up got y=%0d want 3", pos_y); else n_pass++;
    step(0, 0, 0, 1, 0, 0, 16'd0);
    n_total++; if (pos_x !== 3'd0) $display("FAIL wrap_right got x=%0d want 0", pos_x); else n_pass++;
    step(0, 1, 0, 0, 0, 0, 16'd0);
    n_total++; if (pos_y !== 2'd0) $display("FAIL wrap_down got y=%0d want 0", pos_y); else n_pass++;
    step(0, 1, 1, 1, 0, 0, 16'd0);
    n_total++; if ({pos_x, pos_y} !== {3'd0, 2'd1}) $display("FAIL move_priority got x=%0d y=%0d want 0 1", pos_x, pos_y); else n_pass++;
  endtask

  task automatic test_full_calc();
    do_reset();
    mode = 1;
    press_digit(1);
    press_digit(2);
    press_key(4, 2);
    n_total++; if (op1 !== 16'h0012) $display("FAIL calc_op1 got %h want 0012", op1); else n_pass++;
    press_digit(3);
    n_total++; if (input_screen !== 16'h0003) $display("FAIL calc_entry2 got %h want 0003", input_screen); else n_pass++;
    press_key(5, 3);
    n_total++; if (op !== 3'd0) $display("FAIL calc_op got %0d want 0", op); else n_pass++;
    n_total++; if (op2 !== 16'h0003) $display("FAIL calc_op2 got %h want 0003", op2); else n_pass++;
    n_total++; if (alu_start !== 1'b1) $display("FAIL calc_start got %b want 1", alu_start); else n_pass++;
    n_total++; if (state !== 2'd2) $display("FAIL calc_wait got %0d want 2", state); else n_pass++;
    idle();
    n_total++; if (alu_start !== 1'b0) $display("FAIL calc_start_width got %b want 0", alu_start); else n_pass++;
    finish_alu(16'h0015);
    n_total++; if (input_screen !== 16'h0015) $display("FAIL calc_result got %h want 0015", input_screen); else n_pass++;
    n_total++; if (state !== 2'd3) $display("FAIL calc_state got %0d want 3", state); else n_pass++;
  endtask

  task automatic test_chain();
    press_key(5, 2);
    press_digit(2);
    press_key(5, 3);
    n_total++; if (op1 !== 16'h0015) $display("FAIL chain_op1 got %h want 0015", op1); else n_pass++;
    n_total++; if (op !== 3'd1) $display("FAIL chain_op got %0d want 1", op); else n_pass++;
    n_total++; if (op2 !== 16'h0002) $display("FAIL chain_op2 got %h want 0002", op2); else n_pass++;
    finish_alu(16'h0013);
    step(0, 0, 0, 0, 0, 1, 16'h7777);
    n_total++; if (op1 !== 16'h0013) $display("FAIL late_done got op1=%h want 0013", op1); else n_pass++;
  endtask

  task automatic test_entry_limit();
    do_reset();
    mode = 0;
    for (int dgt = 1; dgt <= 5; dgt++) press_digit(dgt);
    press_key(4, 1);
    n_total++; if (input_screen !== 16'h1234) $display("FAIL entry_limit got %h want 1234", input_screen); else n_pass++;
    mode = 1;
    idle();
    n_total++; if (input_screen !== 16'h1234) $display("FAIL mode_change got %h want 1234", input_screen); else n_pass++;
    press_key(3, 3);
    n_total++; if (input_screen !== 16'h0000) $display("FAIL ce got %h want 0000", input_screen); else n_pass++;
  endtask

  task automatic test_coincident_abort();
    do_reset();
    mode = 1;
    step(0, 0, 0, 1, 1, 0, 16'd0);
    n_total++; if (pos_x !== 3'd1) $display("FAIL coinc_pos got x=%0d want 1", pos_x); else n_pass++;
    for (int dgt = 1; dgt <= 4; dgt++) press_digit(dgt);
    n_total++; if (input_screen !== 16'h0123) $display("FAIL coinc_digit got %h want 0123", input_screen); else n_pass++;
    press_key(4, 2);
    press_digit(5);
    press_key(5, 3);
    press_key(4, 3);
    n_total++; if (state !== 2'd0) $display("FAIL clr_wait_state got %0d want 0", state); else n_pass++;
    finish_alu(16'habcd);
    n_total++; if (state !== 2'd0) $display("FAIL clr_done_state got %0d want 0", state); else n_pass++;
    n_total++; if ({input_screen, op1} !== 32'd0) $display("FAIL clr_done_vals got screen=%h op1=%h want 0 0", input_screen, op1); else n_pass++;
  endtask

  task automatic test_reset_abort();
    do_reset();
    press_digit(7);
    press_key(0, 3);
    press_digit(1);
    press_key(5, 3);
    do_reset();
    finish_alu(16'hbeef);
    n_total++; if (state !== 2'd0) $display("FAIL rst_abort_state got %0d want 0", state); else n_pass++;
    n_total++; if ({input_screen, op1} !== 32'd0) $display("FAIL rst_abort_vals got screen=%h op1=%h want 0 0", input_screen, op1); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, 16'($urandom));
      n_total++;
      if (pos_x !== 3'(m_x) || pos_y !== 2'(m_y) || op1 !== m_op1 || op2 !== m_op2 || op !== 3'(m_op) ||
          input_screen !== m_screen() || state !== 2'(m_state) || alu_start !== m_start) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle %0d got x=%0d y=%0d op1=%h op2=%h op=%0d scr=%h st=%0d start=%b want x=%0d y=%0d op1=%h op2=%h op=%0d scr=%h st=%0d start=%b",
                   i, pos_x, pos_y, op1, op2, op, input_screen, state, alu_start,
                   m_x, m_y, m_op1, m_op2, m_op, m_screen(), m_state, m_start);
      end else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap();
    test_full_calc();
    test_chain();
    test_entry_limit();
    test_coincident_abort();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_keypad_controller.md
CALC_KEYPAD_CONTROLLER -- requirements
Module: calc_keypad_controller

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 4, giving the maximum nibbles accepted per entry (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, which is the VGA pixel clock domain.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_center, input, 1 bit each: debounced single-cycle pulses.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = decimal (BCD digits 0-9 only), 1 = hexadecimal.
REQ-006 The block SHALL have ports pos_x, output, 3 bits, and pos_y, output, 2 bits: cursor cell in the 6x4 key grid.
REQ-007 The block SHALL have ports op1 and op2, output, 16 bits each: latched operands.
REQ-008 The block SHALL have port op, output, 3 bits: operation code, where 0=ADD, 1=SUB, 2=MUL, 3=AND, 4=OR.
REQ-009 The block SHALL have port input_screen, output, 16 bits: value shown on the entry display.
REQ-010 The block SHALL have port state, output, 2 bits: 0=S_OP1, 1=S_OP2, 2=S_WAIT, 3=S_RESULT.
REQ-011 The block SHALL have port alu_start, output, 1 bit: one-cycle start pulse to the ALU.
REQ-012 The block SHALL have ports alu_done, input, 1 bit, and alu_result, input, 16 bits: ALU completion strobe and its result.

Function
REQ-013 All outputs SHALL be registered; a press takes effect on outputs in the cycle after the pulse.
REQ-014 Key map SHALL be row y0 = 0 1 2 3 4 5; y1 = 6 7 8 9 A B; y2 = C D E F ADD SUB; y3 = MUL AND OR CE CLR EXE, with x = column 0..5.
REQ-015 Cursor movement SHALL wrap: right from x=5 goes to 0, left from x=0 goes to 5, down from y=3 goes to 0, up from y=0 goes to 3.
REQ-016 When several move pulses coincide, only one SHALL be applied, with priority up > down > left > right.
REQ-017 btn_center SHALL decode the key at the pre-move cursor position, even when a move pulse occurs in the same cycle.
REQ-018 Digit entry SHALL shift the internal entry left: entry <= {entry[11:0], digit}, and increment a digit count.
REQ-019 Digits SHALL be ignored when the digit count equals MAX_DIGITS.
REQ-020 Keys A-F SHALL be ignored when mode = 0; changing mode SHALL NOT alter any stored value.
REQ-021 In S_OP1:
  - a digit SHALL update entry;
  - an op key SHALL set op1 <= entry, set op <= code, clear entry and count, and go to S_OP2;
  - EXE SHALL be ignored.
REQ-022 In S_OP2:
  - a digit SHALL update entry;
  - an op key SHALL replace op and stay in S_OP2;
  - EXE SHALL set op2 <= entry, pulse alu_start for exactly one cycle, and go to S_WAIT.
REQ-023 In S_WAIT, all center presses except CLR SHALL be ignored, and cursor movement SHALL remain active.
REQ-024 In S_WAIT, alu_done SHALL set input_screen <= alu_result and op1 <= alu_result, clear entry, and go to S_RESULT.
REQ-025 In S_RESULT:
  - a digit SHALL set entry <= digit and count = 1, and go to S_OP1;
  - an op key SHALL set op <= code, keep op1 (result chaining), clear entry, and go to S_OP2;
  - EXE SHALL be ignored.
REQ-026 CE SHALL clear entry and count. CE SHALL be ignored in S_WAIT. From S_RESULT, CE SHALL go to S_OP1.
REQ-027 CLR SHALL be honoured in any state, including S_WAIT. It SHALL clear op1, op2, op, entry and count, set input_screen = 0, and go to S_OP1. The cursor SHALL be kept.
REQ-028 alu_done SHALL be ignored outside S_WAIT.
REQ-029 In S_OP1 and S_OP2, input_screen SHALL equal entry.

Reset
REQ-030 While rst = 1, the block SHALL hold pos_x=0, pos_y=0, op1=0, op2=0, op=0, input_screen=0, state=S_OP1, alu_start=0, entry=0 and count=0, overriding all button pulses.
REQ-031 Reset asserted mid-operation, including in S_WAIT, SHALL abort to S_OP1, and a later alu_done SHALL be ignored.

Verification
REQ-032 Wrap test: from reset, pulse btn_left, then btn_up -> pos_x=5, pos_y=3; then pulse btn_right -> pos_x=0.
REQ-033 Full calculation test, mode=1:
  - stimulus: enter 1, 2; select ADD; enter 3; press EXE;
  - required response: op1=0x0012, op=0, op2=0x0003, alu_start high for exactly 1 cycle;
  - then drive alu_done with alu_result=0x0015 -> input_screen=0x0015, state=S_RESULT.
REQ-034 Entry limit test: mode=0; enter 1, 2, 3, 4, 5; press key A -> input_screen=0x1234.
REQ-035 Chaining test: from S_RESULT with result 0x0015, select SUB, enter 2, press EXE -> op1=0x0015, op=1, op2=0x0002.
REQ-036 Coincident-event and abort test:
  - btn_center at cursor (0,0) together with btn_right -> digit 0 is entered and pos_x becomes 1;
  - CLR pressed during S_WAIT, then alu_done -> state=S_OP1, input_screen=0.
